// File: rtl/width_12to8.sv
`default_nettype none
// ============================================================================
// Module   : width_12to8
// Purpose  : Re-serialises a 12-bit word stream into an MSB-first byte stream
//            through a 20-bit bit-buffer, padding an odd trailing nibble.
// Revision : 1.0 - initial release
// ============================================================================
module width_12to8 #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [11:0] data_in,
    input  logic        last_in,
    output logic        ready_in,
    output logic        valid_out,
    output logic [7:0]  data_out,
    output logic        last_out,
    input  logic        ready_out
);

    localparam logic [4:0] C_CNT_MAX  = 5'd20;
    localparam logic [4:0] C_CNT_BYTE = 5'd8;
    localparam logic [4:0] C_CNT_HALF = 5'd4;
    localparam logic [4:0] C_CNT_WORD = 5'd12;

    logic [19:0] r_buf;
    logic [4:0]  r_cnt;
    logic        r_flush;

    logic        w_pad;
    logic        w_pop;
    logic        w_acc;
    logic [19:0] w_buf_pop;
    logic [4:0]  w_cnt_pop;
    logic [19:0] w_ins;
    logic [19:0] w_keep;
    logic [19:0] w_buf_nxt;
    logic [4:0]  w_cnt_nxt;
    logic        w_flush_nxt;

    // All outputs decode registered state only; no input-to-output paths.
    assign w_pad     = r_flush && (r_cnt == C_CNT_HALF);
    assign valid_out = (r_cnt >= C_CNT_BYTE) || w_pad;
    assign data_out  = w_pad ? {r_buf[19:16], PAD_NIBBLE} : r_buf[19:12];
    assign last_out  = r_flush && ((r_cnt == C_CNT_BYTE) || (r_cnt == C_CNT_HALF));
    assign ready_in  = !rst && !r_flush && (r_cnt <= C_CNT_BYTE);

    assign w_pop = valid_out && ready_out;
    assign w_acc = valid_in && ready_in;

    always_comb begin
        w_buf_pop = r_buf;
        w_cnt_pop = r_cnt;
        if (w_pop) begin
            w_buf_pop = r_buf << 8;
            // The padded byte only holds 4 real bits, so the count floors at 0.
            w_cnt_pop = (r_cnt >= C_CNT_BYTE) ? (r_cnt - C_CNT_BYTE) : 5'd0;
        end
    end

    // New word lands directly below the bits that survive this cycle's pop.
    assign w_ins  = {data_in, 8'h00} >> w_cnt_pop;
    assign w_keep = ~(20'hF_FFFF >> w_cnt_pop);

    always_comb begin
        w_buf_nxt   = w_buf_pop;
        w_cnt_nxt   = w_cnt_pop;
        w_flush_nxt = r_flush;
        if (w_acc) begin
            w_buf_nxt = (w_buf_pop & w_keep) | w_ins;
            w_cnt_nxt = w_cnt_pop + C_CNT_WORD;
            if (last_in) begin
                w_flush_nxt = 1'b1;
            end
        end else if (w_pop && last_out) begin
            w_flush_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf   <= 20'h0_0000;
            r_cnt   <= 5'd0;
            r_flush <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flush <= w_flush_nxt;
        end
    end

`ifndef SYNTHESIS
    a_cnt_max : assert property (@(posedge clk) disable iff (rst) r_cnt <= C_CNT_MAX);
`endif

endmodule
`default_nettype wire
